// File: rtl/serial_mult4.sv
// serial_mult4: unsigned W x W shift-add multiplier, one step per clock.
// Optional DONE_ACK_EN: hold the result in DONE until ack is seen.
module serial_mult4 #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           ack,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_n;

    logic [2*W:0]  p;
    logic [W-1:0]  m;
    logic [CW-1:0] cnt;
    logic [W:0]    s;
    logic [1:0]    unused_bits;

    // ack is only consulted with DONE_ACK_EN; P's top bit never reaches product
    assign unused_bits = {ack, p[2*W]};

    // Partial-product add with its carry kept as the sum's top bit
    always_comb begin
        s = {1'b0, p[2*W-1:W]} + {1'b0, (p[0] ? m : {W{1'b0}})};
    end

    // Next-state decode
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = RUN;
            RUN:  if (cnt == LAST) state_n = DONE;
`ifdef DONE_ACK_EN
            DONE: if (ack) state_n = IDLE;
`else
            DONE: state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase
    end

    // State register with registered busy/done decodes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n == RUN);
            done  <= (state_n == DONE);
        end
    end

    // Operand capture and one shift-add step per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p   <= '0;
            m   <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        p   <= {1'b0, {W{1'b0}}, b};
                        m   <= a;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    p   <= {1'b0, s, p[W-1:1]};
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign product = p[2*W-1:0];

endmodule

// File: tb/tb_serial_mult4.sv
// tb_serial_mult4: directed checks of serial_mult4 at W=4.
// Covers latency, start hold, mid-RUN reset, DONE handling and a full sweep.
module tb_serial_mult4;

    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           ack;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int vectors;
    int miscompares;
    int lat;
    int bcnt;

    serial_mult4 #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ack     (ack),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Leave DONE: ack it when required, otherwise it must be a 1-cycle pulse
    task automatic leave_done(input string tag);
`ifdef DONE_ACK_EN
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
`else
        @(posedge clk);
        #1;
`endif
        chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    endtask

    // Wait for done after the start edge, counting latency and busy cycles
    task automatic wait_done();
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic do_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [2*W-1:0] exp, input string tag);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
        wait_done();
        chk({tag, "_lat"}, lat, W);
        chk({tag, "_busycyc"}, bcnt, W);
        chk({tag, "_excl"}, {31'd0, busy}, 32'd0);
        chk({tag, "_prod"}, {24'd0, product}, {24'd0, exp});
        leave_done(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        a           = '0;
        b           = '0;
        ack         = 1'b0;

        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_prod", {24'd0, product}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_mul(4'd15, 4'd15, 8'hE1, "m15x15");
        do_mul(4'd9, 4'd7, 8'd63, "m9x7");
        do_mul(4'd0, 4'd13, 8'd0, "m0x13");

        // start held through RUN with operands changed mid-run
        @(negedge clk);
        a     = 4'd6;
        b     = 4'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_busy0", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        a = 4'd15;
        b = 4'd15;
        wait_done();
        chk("hold_lat", lat + 1, W);
        chk("hold_prod", {24'd0, product}, 32'd30);
        leave_done("hold");
        chk("hold_norestart", {31'd0, busy}, 32'd0);
        chk("hold_keep", {24'd0, product}, 32'd30);
        start = 1'b0;

        // reset pulsed during RUN step 2
        @(negedge clk);
        a     = 4'd13;
        b     = 4'd11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_prod", {24'd0, product}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("arst_nodone", {31'd0, done}, 32'd0);
        end
        #1;
        rst_n = 1'b1;
        do_mul(4'd3, 4'd4, 8'd12, "m3x4");

`ifdef DONE_ACK_EN
        // DONE persists while ack is withheld
        @(negedge clk);
        a     = 4'd11;
        b     = 4'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        chk("ack_lat", lat, W);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("ack_held", {31'd0, done}, 32'd1);
            chk("ack_prod", {24'd0, product}, 32'd22);
        end
        leave_done("ack");
        chk("ack_idle", {31'd0, busy}, 32'd0);
`else
        // ack is ignored; done is still a single-cycle pulse
        @(negedge clk);
        ack = 1'b0;
        do_mul(4'd11, 4'd2, 8'd22, "m11x2");
`endif

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                do_mul(4'(x), 4'(y), 8'(x * y), "sweep");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_mult4.md
SERIAL_MULT4 -- requirements
Module: serial_mult4

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the unsigned operand width; supported values are 2 to 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply; it is sampled only in IDLE.
REQ-005 The block SHALL have port a, input, W bits: multiplicand, captured when start is accepted.
REQ-006 The block SHALL have port b, input, W bits: multiplier, captured when start is accepted.
REQ-007 The block SHALL have port ack, input, 1 bit: result acknowledge, used only when DONE_ACK_EN is defined and ignored otherwise.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-009 The block SHALL have port done, output, 1 bit: high while in DONE, meaning product is valid.
REQ-010 The block SHALL have port product, output, 2W bits: the unsigned product a*b.

Function
REQ-011 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE, with IDLE as the reset state.
REQ-012 In IDLE, when start=1 at a rising edge, the block SHALL do all of the following at that edge:
- load the upper half of the internal (2W+1)-bit register P with 0, the lower half with b, and the top carry bit with 0;
- latch a into register M;
- clear the step counter;
- enter RUN.
REQ-013 The block SHALL perform one shift-add step on each RUN edge: s = P[2W-1:W] + (P[0] ? M : 0) as a (W+1)-bit sum including carry, then P <= {s, P[W-1:1]} (the carry lands in P[2W-1]), then counter increments.
REQ-014 The block SHALL perform exactly W steps, with the step-W edge moving to DONE, so done rises W edges after the start-sampling edge (4 for W=4).
REQ-015 The product output SHALL be driven from P[2W-1:0] and SHALL hold its value unchanged from DONE until the next accepted start.
REQ-016 The block SHALL ignore start while in RUN or DONE, so it has no effect on operands or state.
REQ-017 The block SHALL NOT overflow: the product of two W-bit unsigned values always fits in 2W bits, and the sum carry is never discarded.
REQ-018 The step counter SHALL be wide enough to hold W and SHALL never wrap during RUN.
REQ-019 busy and done SHALL be registered decodes of state and SHALL never be high simultaneously.

Reset
REQ-020 When rst_n=0, the block SHALL immediately force state=IDLE, busy=0, done=0, product=0, P=0, M=0 and counter=0, independent of clk.
REQ-021 Reset asserted mid-RUN SHALL abort the operation with no done pulse, and after release the block SHALL accept a new start on the first edge.
REQ-022 Release of rst_n is synchronous to clk by the integrating design, and the block SHALL take no action on the release edge other than normal IDLE sampling.

Configuration
REQ-023 With macro DONE_ACK_EN defined, DONE SHALL persist until ack=1 at an edge and then go to IDLE, and ack in any other state SHALL be ignored.
REQ-024 Without DONE_ACK_EN, DONE SHALL last exactly one cycle (done is a one-cycle pulse) and then go to IDLE unconditionally, and the ack port SHALL remain present but unused.

Verification
REQ-025 The bench SHALL cover: a=15, b=15, start pulse -> busy for 4 cycles, done at edge 4, product=225 (0xE1).
REQ-026 The bench SHALL cover: a=9, b=7 -> product=63, and a=0, b=13 -> product=0, each with latency 4.
REQ-027 The bench SHALL cover: a=6, b=5 with start held high through RUN and a, b changed mid-RUN -> product=30, and no restart occurs until IDLE.
REQ-028 The bench SHALL cover: rst_n pulsed low at RUN step 2 -> all outputs 0 immediately, done never asserts, and a subsequent a=3, b=4 gives product=12.
REQ-029 The bench SHALL cover, with DONE_ACK_EN, a=11, b=2 and ack withheld for 5 cycles -> done and product=22 held, IDLE one edge after ack=1; without DONE_ACK_EN -> done high for exactly one cycle.
REQ-030 The bench SHALL cover: an exhaustive sweep of all 256 (a, b) pairs for W=4, with each product checked against a*b.
